// File: rtl/vx_alu_issue_arb.sv
// vx_alu_issue_arb
//   Round-robin arbiter sharing one ALU request port among NUM_REQS issue
//   requesters. At most one request is granted per cycle into a registered
//   output stage. With ALU_ARB_BR_LOCK_EN defined, a warp that has issued a
//   branch is blocked until the branch-control response for that warp returns.
//
// Configuration macro: ALU_ARB_BR_LOCK_EN (branch lockout, default off)
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   req_valid/data/wid/is_br per-requester request (flattened per requester)
//   req_ready               one-hot grant (combinational)
//   out_valid/data/wid/sel  registered request toward the ALU
//   out_ready               ALU accepts
//   br_valid, br_wid        branch resolved for warp br_wid
//   br_pending              per-warp branch-pending mask
module vx_alu_issue_arb #(
    parameter int NUM_REQS  = 4,
    parameter int DATAW     = 64,
    parameter int NUM_WARPS = 4,
    parameter int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int REQ_SELW  = $clog2(NUM_REQS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQS-1:0]         req_valid,
    input  logic [NUM_REQS*DATAW-1:0]   req_data,
    input  logic [NUM_REQS*NW_BITS-1:0] req_wid,
    input  logic [NUM_REQS-1:0]         req_is_br,
    output logic [NUM_REQS-1:0]         req_ready,
    output logic                        out_valid,
    output logic [DATAW-1:0]            out_data,
    output logic [NW_BITS-1:0]          out_wid,
    output logic [REQ_SELW-1:0]         out_sel,
    input  logic                        out_ready,
    input  logic                        br_valid,
    input  logic [NW_BITS-1:0]          br_wid,
    output logic [NUM_WARPS-1:0]        br_pending
);

    logic [NUM_REQS-1:0] elig;
    logic                en;
    logic                gnt_any;
    logic                gnt_vld;
    logic [REQ_SELW-1:0] gnt_idx;
    logic [REQ_SELW:0]   cand;
    logic [NW_BITS-1:0]  gnt_wid;
    logic [REQ_SELW-1:0] ptr;

    assign en = out_ready | ~out_valid;

`ifdef ALU_ARB_BR_LOCK_EN
    logic [NUM_WARPS-1:0] pend_q;
    logic [NUM_WARPS-1:0] pend_nxt;

    assign br_pending = pend_q;

    // A requester whose warp has a branch in flight is not eligible.
    always_comb begin
        elig = req_valid;
        for (int i = 0; i < NUM_REQS; i++) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (req_wid[i*NW_BITS +: NW_BITS] == NW_BITS'(w) && pend_q[w])
                    elig[i] = 1'b0;
            end
        end
    end

    // Clear first, then set, so a forced same-warp set/clear leaves it pending.
    always_comb begin
        pend_nxt = pend_q;
        if (br_valid) begin
            for (int w = 0; w < NUM_WARPS; w++)
                if (br_wid == NW_BITS'(w)) pend_nxt[w] = 1'b0;
        end
        if (gnt_vld && req_is_br[gnt_idx]) begin
            for (int w = 0; w < NUM_WARPS; w++)
                if (gnt_wid == NW_BITS'(w)) pend_nxt[w] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_nxt;
    end
`else
    logic unused_br;

    assign elig       = req_valid;
    assign br_pending = '0;
    assign unused_br  = ^{br_valid, br_wid, req_is_br};
`endif

    // Round-robin pick: scan offsets from the far end down to zero so the
    // eligible index closest to ptr is the last (winning) assignment.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int j = NUM_REQS-1; j >= 0; j--) begin
            cand = {1'b0, ptr} + (REQ_SELW+1)'(j);
            if (cand >= (REQ_SELW+1)'(NUM_REQS))
                cand = cand - (REQ_SELW+1)'(NUM_REQS);
            if (elig[cand[REQ_SELW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[REQ_SELW-1:0];
            end
        end
    end

    // No grant may be presented while reset is asserted.
    assign gnt_vld = gnt_any & en & ~reset;
    assign gnt_wid = req_wid[int'(gnt_idx)*NW_BITS +: NW_BITS];

    always_comb begin
        req_ready = '0;
        if (gnt_vld) req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_wid   <= '0;
            out_sel   <= '0;
        end else if (en) begin
            out_valid <= gnt_vld;
            if (gnt_vld) begin
                out_data <= req_data[int'(gnt_idx)*DATAW +: DATAW];
                out_wid  <= gnt_wid;
                out_sel  <= gnt_idx;
                ptr      <= (gnt_idx == REQ_SELW'(NUM_REQS-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule
